// File: rtl/register_file_read.sv
// 32-entry register file ($0 hardwired to zero) with A/B operand latches and write-to-read forwarding.
// Read_DataN is combinational, A_Out/B_Out have one cycle of latency; one write and two reads per cycle, never stalls.
module register_file_read #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Write_Reg,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic [ADDR_WIDTH-1:0] Read_Reg1,
  input  logic [ADDR_WIDTH-1:0] Read_Reg2,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  output logic [DATA_WIDTH-1:0] A_Out,
  output logic [DATA_WIDTH-1:0] B_Out
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  wr_en;
  logic                  fwd1;
  logic                  fwd2;

  // Writes to $0 are dropped here so entry 0 never leaves its reset value.
  assign wr_en = RegWrite && (Write_Reg != '0);
  assign fwd1  = wr_en && (Write_Reg == Read_Reg1);
  assign fwd2  = wr_en && (Write_Reg == Read_Reg2);

  assign Read_Data1 = (Read_Reg1 == '0) ? '0 : regs[Read_Reg1];
  assign Read_Data2 = (Read_Reg2 == '0) ? '0 : regs[Read_Reg2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Write_Reg] <= Write_Data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A_Out <= '0;
      B_Out <= '0;
    end else begin
      A_Out <= fwd1 ? Write_Data : Read_Data1;
      B_Out <= fwd2 ? Write_Data : Read_Data2;
    end
  end

endmodule

// File: tb/tb_register_file_read.sv
// Directed bench for register_file_read: array-based reference model checked every negedge,
// plus hand-computed literal expectations along the directed sequence.
module tb_register_file_read;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Reg1;
  logic [4:0]  Read_Reg2;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic [31:0] A_Out;
  logic [31:0] B_Out;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_a;
  logic [31:0] m_b;

  register_file_read #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .Write_Reg(Write_Reg),
    .Write_Data(Write_Data), .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2), .A_Out(A_Out), .B_Out(B_Out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : m_regs[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as a plain array, operands pick the pending write when it targets the read index.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_a = 32'h0;
      m_b = 32'h0;
    end else begin
      logic [31:0] na;
      logic [31:0] nb;
      bit          w;
      w  = RegWrite && (Write_Reg != 5'd0);
      na = (w && Write_Reg == Read_Reg1) ? Write_Data : mread(Read_Reg1);
      nb = (w && Write_Reg == Read_Reg2) ? Write_Data : mread(Read_Reg2);
      if (w) m_regs[Write_Reg] = Write_Data;
      m_a = na;
      m_b = nb;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rd1", Read_Data1, mread(Read_Reg1));
      chk("model_rd2", Read_Data2, mread(Read_Reg2));
      chk("model_a", A_Out, m_a);
      chk("model_b", B_Out, m_b);
    end
  end

  task automatic set(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2);
    RegWrite   = we;
    Write_Reg  = wr;
    Write_Data = wd;
    Read_Reg1  = r1;
    Read_Reg2  = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();
    cmp_en = 1'b1;
    chk("reset_a", A_Out, 32'h0);
    chk("reset_b", B_Out, 32'h0);
    reset = 1'b0;

    // Preload reg 5, then assert reset mid-cycle
    set(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    tick();
    chk("preload_rd1", Read_Data1, 32'hDEADBEEF);
    chk("preload_a_fwd", A_Out, 32'hDEADBEEF);
    set(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_a", A_Out, 32'h0);
    chk("async_reset_b", B_Out, 32'h0);
    chk("async_reset_rd1", Read_Data1, 32'h0);
    set(1'b1, 5'd5, 32'h55555555, 5'd5, 5'd5);
    tick();
    reset = 1'b0;
    set(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    tick();
    chk("write_in_reset_dropped", Read_Data1, 32'h0);

    // Basic write/read
    set(1'b1, 5'd8, 32'h12345678, 5'd0, 5'd0);
    tick();
    set(1'b1, 5'd9, 32'hCAFEF00D, 5'd8, 5'd9);
    #1;
    chk("basic_rd1", Read_Data1, 32'h12345678);
    tick();
    chk("basic_a", A_Out, 32'h12345678);
    chk("basic_b_fwd", B_Out, 32'hCAFEF00D);

    // $0 immutability
    set(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd8);
    tick();
    chk("zero_rd1", Read_Data1, 32'h0);
    chk("zero_a", A_Out, 32'h0);
    chk("zero_b_other", B_Out, 32'h12345678);

    // Forwarding to both ports
    set(1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0);
    tick();
    set(1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3);
    #1;
    chk("fwd_rd1_before", Read_Data1, 32'h11111111);
    tick();
    chk("fwd_a", A_Out, 32'h22222222);
    chk("fwd_b", B_Out, 32'h22222222);

    // Forwarding suppression
    set(1'b0, 5'd3, 32'h33333333, 5'd3, 5'd9);
    tick();
    chk("nofwd_a", A_Out, 32'h22222222);
    chk("nofwd_rd1", Read_Data1, 32'h22222222);
    set(1'b0, 5'd0, 32'h33333333, 5'd0, 5'd3);
    tick();
    chk("nofwd_zero_a", A_Out, 32'h0);
    set(1'b0, 5'bx, 32'h44444444, 5'd3, 5'd9);
    tick();
    chk("xaddr_a", A_Out, 32'h22222222);
    chk("xaddr_b", B_Out, 32'hCAFEF00D);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      set(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      set(1'b0, 5'd0, 32'h0, 5'(i), 5'((32 - i) % 32));
      tick();
      chk("sweep_a", A_Out, 32'(i) * 32'h01010101);
      chk("sweep_b", B_Out, 32'((32 - i) % 32) * 32'h01010101);
    end

    // Reset mid-sweep, everything reads zero until rewritten
    for (int i = 1; i < 16; i++) begin
      set(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    set(1'b1, 5'd16, 32'h10101010, 5'd7, 5'd16);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set(1'b0, 5'd0, 32'h0, 5'(i), 5'((32 - i) % 32));
      tick();
      chk("postrst_a", A_Out, 32'h0);
      chk("postrst_b", B_Out, 32'h0);
    end
    set(1'b1, 5'd7, 32'h07070707, 5'd0, 5'd0);
    tick();
    set(1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
    tick();
    chk("rewrite_a", A_Out, 32'h07070707);
    chk("rewrite_b", B_Out, 32'h0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
